pcpi_issue_ctrl: RTL
====================

# pcpi_issue_ctrl

Core-side initiator for the PCPI coprocessor interface. It accepts one decoded instruction and its operands from the execute stage, drives the PCPI bus, and waits for a coprocessor to answer with `pcpi_ready`. If no coprocessor claims the instruction within a bounded time, it reports an illegal-instruction trap instead. The result (or trap) is held in a response buffer until writeback consumes it. The block pairs with PCPI responders such as the multiply coprocessor.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: number of consecutive no-`pcpi_wait` cycles tolerated before a trap. 0 disables the timeout, so the block waits forever.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `req_valid` in 1: execute stage offers an instruction.
- `req_ready` out 1: block can accept a request.
- `req_insn` in 32: instruction word.
- `req_rs1` in 32: operand 1.
- `req_rs2` in 32: operand 2.
- `pcpi_valid` out 1: instruction presented on PCPI.
- `pcpi_insn` out 32: registered instruction.
- `pcpi_rs1` out 32: registered operand 1.
- `pcpi_rs2` out 32: registered operand 2.
- `pcpi_wr` in 1: responder writes `rd`.
- `pcpi_rd` in 32: responder result.
- `pcpi_wait` in 1: responder has claimed the instruction and is busy.
- `pcpi_ready` in 1: responder finished; `pcpi_wr` and `pcpi_rd` are valid this cycle.
- `rsp_valid` out 1: response buffer full.
- `rsp_ready` in 1: writeback consumes the response.
- `rsp_wr` out 1: write `rsp_rd` to the register file.
- `rsp_rd` out 32: result.
- `rsp_trap` out 1: no responder claimed the instruction (illegal instruction).
- `busy` out 1: the state is not IDLE.

## Operation
- States: IDLE, ISSUE, RESP.
- `req_ready` = (state == IDLE).
- `busy` = (state != IDLE).
- `pcpi_valid` = (state == ISSUE).
- `rsp_valid` = (state == RESP).
- IDLE:
  - On `req_valid && req_ready`, capture `insn`, `rs1` and `rs2` into the `pcpi_*` registers.
  - Load the timeout counter with `TIMEOUT_CYCLES` and go to ISSUE.
- ISSUE evaluates conditions in this priority order each cycle:
  1. `pcpi_ready`: capture `rsp_wr`←`pcpi_wr`, `rsp_rd`←`pcpi_rd`, `rsp_trap`←0; go to RESP.
  2. `pcpi_wait`: reload the counter with `TIMEOUT_CYCLES`.
  3. Counter == 0 and `TIMEOUT_CYCLES` != 0: `rsp_trap`←1, `rsp_wr`←0, `rsp_rd`←0; go to RESP.
  4. Otherwise, decrement the counter when `TIMEOUT_CYCLES` != 0.
- `pcpi_ready` in the same cycle as counter == 0: the result wins and no trap is raised.
- RESP: hold `rsp_*` stable. On `rsp_ready`, go to IDLE.
- `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` are stable for the whole of ISSUE; responders sample the operands at any point in that window.
- `pcpi_ready`, `pcpi_wr` and `pcpi_wait` are ignored outside ISSUE.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- No arithmetic is performed on the data path. All 32-bit values pass through unchanged.

## Timing
- Reset (`resetn`=0 at a clock edge):
  - State goes to IDLE.
  - `pcpi_valid`, `rsp_valid`, `rsp_wr`, `rsp_trap` and `busy` go to 0.
  - `rsp_rd`, `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` go to 0.
  - The counter goes to 0.
- Reset mid-ISSUE drops `pcpi_valid` in the next cycle. Any `pcpi_ready` sampled with reset low is discarded.
- Request accepted at edge 0: `pcpi_valid`=1 from cycle 1.
- `pcpi_ready` sampled at edge k: `pcpi_valid`=0 and `rsp_valid`=1 from cycle k+1.
- Minimum issue-to-response latency is 2 cycles.
- `pcpi_valid` is low for at least 2 cycles between consecutive instructions (RESP, then IDLE). This guarantees responders see a falling edge of `pcpi_valid`/`pcpi_wait` before the next instruction.
- Timeout with `pcpi_wait` never asserted:
  - `pcpi_valid` is high for `TIMEOUT_CYCLES`+1 cycles.
  - `rsp_valid` with `rsp_trap` appears in cycle `TIMEOUT_CYCLES`+2 after acceptance.
- `rsp_ready` held high in RESP gives a single-cycle response. The next `req_ready` is in the following cycle.

## Structure
- A shared package `pcpi_pkg` holds:
  - the state enum (IDLE/ISSUE/RESP);
  - `PCPI_XLEN` = 32;
  - the response struct {`wr`, `trap`, `rd`}, reused by the core writeback mux.
- Sub-module `pcpi_timeout_ctr` (parameterised reload, `load`/`dec` inputs, `zero` output) is natural and reusable by other bus watchdogs.
- The rest is a single FSM plus registers.

## Test plan
- Pair with the PCPI multiply coprocessor; issue MUL (funct7=0000001, funct3=000, opcode 0110011) with rs1=7, rs2=6 → `rsp_valid`, `rsp_wr`=1, `rsp_rd`=42, `rsp_trap`=0; `pcpi_rs1` stays 7 throughout ISSUE.
- MULH with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → `rsp_rd`=0x00000000; MULHU with the same operands → `rsp_rd`=0xFFFFFFFE. Issue the two back-to-back; `pcpi_valid` is low for ≥2 cycles between them.
- No responder, `TIMEOUT_CYCLES`=16 → `pcpi_valid` high exactly 17 cycles, then `rsp_trap`=1, `rsp_wr`=0, `rsp_rd`=0.
- Stub responder asserts `pcpi_wait` for 40 cycles, then `pcpi_ready` with `rd`=0x12345678, `wr`=1 → no trap, `rsp_rd`=0x12345678. Also stub `pcpi_ready` exactly on the counter==0 cycle → result, no trap.
- `rsp_ready` held low for 5 cycles → `rsp_*` stable, `req_ready`=0 and a new `req_valid` is not accepted; then `rsp_ready`=1 → IDLE and `req_ready`=1 next cycle.
- `resetn`=0 for one cycle mid-ISSUE (with `pcpi_ready` asserted in that same cycle) → next cycle `pcpi_valid`=0, `rsp_valid`=0, `req_ready`=1. Also a spurious `pcpi_ready` in IDLE → no response.

Source files
------------

// File: rtl/pcpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_pkg
//  Description : Shared PCPI types: issue FSM states, data width, the
//                response record used by the issue controller and the core
//                writeback mux, and the watchdog counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcpi_pkg;

    localparam int PCPI_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } pcpi_state_e;

    typedef struct packed {
        logic                 wr;
        logic                 trap;
        logic [PCPI_XLEN-1:0] rd;
    } pcpi_rsp_t;

    // Width needed to hold a reload value of n; never narrower than one bit
    function automatic int pcpi_ctr_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcpi_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_timeout_ctr
//  Description : Loadable down-counter for bus watchdogs. load reloads with
//                RELOAD, dec counts down and saturates at zero, zero flags
//                the expired state.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcpi_timeout_ctr #(
    parameter int RELOAD = 16,
    parameter int WIDTH  = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [WIDTH-1:0] C_RELOAD = WIDTH'(RELOAD);
    localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: reload has priority, decrement never wraps below zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = C_RELOAD;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - C_ONE;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pcpi_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pcpi_issue_ctrl
//  Description : Core-side PCPI initiator. Registers one instruction onto the
//                PCPI bus, waits for a responder, and raises an illegal-
//                instruction trap if nobody claims it before the watchdog
//                expires. The result is held until writeback takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcpi_issue_ctrl
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [PCPI_XLEN-1:0] req_insn,
    input  logic [PCPI_XLEN-1:0] req_rs1,
    input  logic [PCPI_XLEN-1:0] req_rs2,
    output logic                 pcpi_valid,
    output logic [PCPI_XLEN-1:0] pcpi_insn,
    output logic [PCPI_XLEN-1:0] pcpi_rs1,
    output logic [PCPI_XLEN-1:0] pcpi_rs2,
    input  logic                 pcpi_wr,
    input  logic [PCPI_XLEN-1:0] pcpi_rd,
    input  logic                 pcpi_wait,
    input  logic                 pcpi_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_wr,
    output logic [PCPI_XLEN-1:0] rsp_rd,
    output logic                 rsp_trap,
    output logic                 busy
);

    localparam int CTR_W = pcpi_ctr_width(TIMEOUT_CYCLES);
    // A zero timeout means wait forever: the watchdog never counts or fires
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    pcpi_state_e          state_q;
    logic [PCPI_XLEN-1:0] insn_q;
    logic [PCPI_XLEN-1:0] rs1_q;
    logic [PCPI_XLEN-1:0] rs2_q;
    pcpi_rsp_t            rsp_q;

    logic ctr_load;
    logic ctr_dec;
    logic ctr_zero;

    // Watchdog control: arm on acceptance, rearm while a responder is busy,
    // otherwise count down unless a result is arriving this cycle
    always_comb begin
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        if (state_q == ST_IDLE) begin
            ctr_load = req_valid;
        end else if ((state_q == ST_ISSUE) && !pcpi_ready) begin
            ctr_load = pcpi_wait;
            ctr_dec  = TO_EN && !pcpi_wait;
        end
    end

    pcpi_timeout_ctr #(
        .RELOAD (TIMEOUT_CYCLES),
        .WIDTH  (CTR_W)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .load   (ctr_load),
        .dec    (ctr_dec),
        .zero   (ctr_zero)
    );

    // Issue FSM with the bus operand registers and the response buffer
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rsp_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        insn_q  <= req_insn;
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A result arriving on the expiry cycle beats the trap
                    if (pcpi_ready) begin
                        rsp_q.wr   <= pcpi_wr;
                        rsp_q.trap <= 1'b0;
                        rsp_q.rd   <= pcpi_rd;
                        state_q    <= ST_RESP;
                    end else if (!pcpi_wait && TO_EN && ctr_zero) begin
                        rsp_q.wr   <= 1'b0;
                        rsp_q.trap <= 1'b1;
                        rsp_q.rd   <= '0;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign pcpi_valid = (state_q == ST_ISSUE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_wr     = rsp_q.wr;
    assign rsp_trap   = rsp_q.trap;
    assign rsp_rd     = rsp_q.rd;

endmodule
`default_nettype wire
